mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 16-bit synchronous memory port between two requesters:
//  port 0 = proc (fetch/outloc reads), port 1 = program loader/debug master.
//  Latches one command per transaction, drives memory for exactly one cycle, returns read data
//  or write ack to the owner; round-robin (or fixed) arbitration, one outstanding transaction.
// PARAMETERS
//  AW          16  address width (both ports and memory)
//  DW          16  data width
//  FIXED_PRIO  0   0: round-robin on contention; 1: port 0 always wins contention
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  rst         in   1   reset, asynchronous, active-high
//  req0        in   1   port 0 request; command fields below valid while high
//  we0         in   1   port 0 write (1) / read (0)
//  addr0       in   AW  port 0 address
//  wdata0      in   DW  port 0 write data
//  gnt0        out  1   port 0 command consumed (1-cycle pulse)
//  rvalid0     out  1   port 0 response pulse (read data or write ack)
//  rdata0      out  DW  port 0 read data, valid when rvalid0 && !we of that txn
//  req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1   same as port 0, for port 1
//  mem_we      out  1   memory write strobe
//  mem_addr    out  AW  memory address
//  mem_wdata   out  DW  memory write data
//  mem_rdata   in   DW  memory read data, valid 1 cycle after address presented
//  busy        out  1   transaction in flight (state != IDLE)
//  owner       out  1   port currently owning memory (held between txns)
// BEHAVIOUR
//  Reset (async): state=IDLE; gnt*,rvalid*,mem_we,busy=0; mem_addr,mem_wdata,rdata*=0;
//   owner=0; last=1 (port 0 wins first tie). Reset mid-txn aborts it: no gnt/rvalid issued.
//  FSM IDLE -> ISSUE -> RESP -> IDLE; every transaction is exactly 3 cycles, no overlap.
//  IDLE: if req0|req1, pick winner, latch its we/addr/wdata, owner<=winner, go ISSUE.
//   Only req0: port 0. Only req1: port 1. Both: FIXED_PRIO=1 -> 0; else !last.
//   No request: stay IDLE, mem_we=0, mem_addr holds last value.
//  ISSUE: mem_addr/mem_wdata = latched cmd; mem_we = latched we (high this cycle only);
//   gnt<owner>=1 this cycle; last<=owner; go RESP.
//  RESP: read -> rdata<owner><=mem_rdata registered, rvalid<owner>=1 next... specifically
//   rvalid<owner> and rdata<owner> are valid in the RESP cycle itself, mem_rdata sampled
//   combinationally to rdata register at the ISSUE->RESP edge is NOT used: rdata<owner>
//   is driven from mem_rdata during RESP and held in a register afterwards.
//   write -> rvalid<owner>=1 in RESP, rdata unchanged. Go IDLE.
//  Requester rule: hold req and cmd stable until gnt seen; drop req the edge after gnt
//   unless issuing a new command (req still high in IDLE = new txn, allowed).
//  Command change while req high and before gnt: latched value (at IDLE edge) wins.
//  rdata of the non-owner port never changes; gnt/rvalid never asserted on both ports.
//  Throughput: continuous requests on both ports alternate 0,1,0,1 (RR), 1 txn per 3 cycles.
//  Widths: addr/data passed unmodified; no arithmetic.
// TESTING
//  Reset then req0 read addr 0x0005 (mem[5]=0xBEEF) -> gnt0 @ISSUE, mem_we=0,
//   mem_addr=0x0005, rvalid0 and rdata0=0xBEEF @RESP, gnt1/rvalid1 stay 0.
//  req1 write addr 0x0010 data 0x1234 -> mem_we high exactly 1 cycle with 0x0010/0x1234,
//   rvalid1 pulse, later port 0 read of 0x0010 returns 0x1234.
//  req0 and req1 both held high for 6 txns, FIXED_PRIO=0 -> grant order 0,1,0,1,0,1;
//   FIXED_PRIO=1 -> 0,0,0,... port 1 only after req0 drops.
//  First-ever simultaneous request after reset -> port 0 granted (last=1 at reset).
//  Assert rst during ISSUE of a write -> mem_we falls immediately, no gnt/rvalid,
//   state=IDLE, next request completes normally in 3 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous 16-bit memory port between the
// processor (port 0) and the loader/debug master (port 1). One transaction
// is in flight at a time: IDLE picks a winner and latches its command, ISSUE
// drives the memory for exactly one cycle, RESP returns read data or a write
// acknowledge to the owner.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state;
  logic          last;
  logic          cur_we;
  logic          winner;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  // Winner selection for the IDLE cycle: a lone requester wins outright; on
  // contention either port 0 always wins or the port not served last wins.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  // Transaction sequencer with registered memory strobes and handshakes; an
  // asynchronous reset abandons any transaction without a grant or response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      cur_we    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          mem_we  <= 1'b0;
          if (req0 || req1) begin
            owner     <= winner;
            cur_we    <= winner ? we1 : we0;
            mem_we    <= winner ? we1 : we0;
            mem_addr  <= winner ? addr1 : addr0;
            mem_wdata <= winner ? wdata1 : wdata0;
            gnt0      <= ~winner;
            gnt1      <= winner;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_we  <= 1'b0;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          last    <= owner;
          rvalid0 <= ~owner;
          rvalid1 <= owner;
          state   <= RESP;
        end
        RESP: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          busy    <= 1'b0;
          if (!cur_we) begin
            if (owner) begin
              rdata1_q <= mem_rdata;
            end else begin
              rdata0_q <= mem_rdata;
            end
          end
          state <= IDLE;
        end
        default: begin
          mem_we  <= 1'b0;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Read data reaches the owner straight from memory during RESP and is held
  // by the per-port register from then on.
  always_comb begin
    rdata0 = rdata0_q;
    rdata1 = rdata1_q;
    if (state == RESP && !cur_we) begin
      if (owner) begin
        rdata1 = mem_rdata;
      end else begin
        rdata0 = mem_rdata;
      end
    end
  end

endmodule
